// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave register controller.
// Contents: FSM state codes, slave-core status bit positions, core mode codes.
package i2c_pkg;

  // FSM state codes
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PTR  = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RD   = 2'd3;

  // Bit positions inside the slave core status byte
  localparam int unsigned STA    = 0;
  localparam int unsigned STO    = 1;
  localparam int unsigned TX_ACK = 2;
  localparam int unsigned RX_ACK = 3;
  localparam int unsigned RW     = 5;

  // Slave core mode codes
  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_SLAVE = 2'b01;

endpackage

// File: rtl/i2c_reg_bank.sv
// DEPTH x 8-bit register bank shared by the I2C side and the local host.
// Ports:
//   clk, rst                clock, async active-low reset
//   i2c_we/waddr/wdata      I2C write port (wins over host on the same cycle)
//   host_we/waddr/wdata     host write port
//   raddr, rdata_c          single combinational read port (pre-write value)
module i2c_reg_bank #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i2c_we,
  input  logic [AW-1:0] i2c_waddr,
  input  logic [7:0]    i2c_wdata,
  input  logic          host_we,
  input  logic [AW-1:0] host_waddr,
  input  logic [7:0]    host_wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata_c
);

  logic [7:0] mem_q [DEPTH];

  // Single write port; I2C traffic has priority over the host
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 8'h00;
    end else if (i2c_we) begin
      mem_q[i2c_waddr] <= i2c_wdata;
    end else if (host_we) begin
      mem_q[host_waddr] <= host_wdata;
    end
  end

  assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/i2c_slave_reg_ctrl.sv
// Transaction controller + register bank in front of the I2C slave core.
// Decodes core status into pointer / register-write / register-read
// sequences, feeds transmit bytes back to the core, and shares the
// register bank with a local host port (I2C events have priority).
// Ports:
//   clk, rst                         clock, async active-low reset
//   cfg_enable/dev_addr/time_out     configuration inputs
//   slv_status, slv_data_out         status and received byte from the core
//   slv_mode_i2c/addr_device/time_out registered core configuration
//   slv_data_in, slv_tx_data_en      transmit byte and stretch-release pulse
//   host_req/we/addr/wdata           host access request
//   host_rdata, host_ack             host completion
//   i2c_wr_pulse, i2c_wr_addr        notification of an I2C register write
//   busy                             FSM not idle
module i2c_slave_reg_ctrl
  import i2c_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = $clog2(DEPTH),
  parameter int unsigned TX_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_enable,
  input  logic [6:0]    cfg_dev_addr,
  input  logic [19:0]   cfg_time_out,
  input  logic [7:0]    slv_status,
  input  logic [7:0]    slv_data_out,
  output logic [1:0]    slv_mode_i2c,
  output logic [6:0]    slv_addr_device,
  output logic [19:0]   slv_time_out,
  output logic [7:0]    slv_data_in,
  output logic          slv_tx_data_en,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic [7:0]    host_rdata,
  output logic          host_ack,
  output logic          i2c_wr_pulse,
  output logic [AW-1:0] i2c_wr_addr,
  output logic          busy
);

  // Delay stages between a tx load and its enable pulse (last stage is tx_en_q)
  localparam int unsigned SHW = TX_LAT - 1;

  logic [1:0]    mode_q;
  logic [6:0]    dev_q;
  logic [19:0]   tmo_q;
  logic [1:0]    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          rx_lvl_q, tx_lvl_q;
  logic [7:0]    data_in_q, data_in_d;
  logic [SHW-1:0] sh_q, sh_d;
  logic          tx_en_q, tx_en_d;
  logic [7:0]    host_rdata_q, host_rdata_d;
  logic          host_ack_q, host_ack_d;
  logic          wr_pulse_q, wr_pulse_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          busy_q, busy_d;

  logic          rx_evt_c, tx_evt_c, sta_c, sto_c;
  logic          tx_load_c, i2c_we_c, host_serve_c, host_wr_c;
  logic [AW-1:0] raddr_c;
  logic [7:0]    rdata_c;
  logic          unused_status;

  assign unused_status = ^{slv_status[7:4]};

  // Ack bits are levels from the core; sta/sto already arrive as pulses
  assign rx_evt_c = slv_status[RX_ACK] & ~rx_lvl_q;
  assign tx_evt_c = slv_status[TX_ACK] & ~tx_lvl_q;
  assign sta_c    = slv_status[STA];
  assign sto_c    = slv_status[STO];

  // Host is served only in event-free cycles and never in its own ack cycle
  assign host_serve_c = host_req & ~rx_evt_c & ~tx_evt_c & ~host_ack_q;
  assign host_wr_c    = host_serve_c & host_we;

  // Tx load and host read never coincide, so one read port suffices
  assign raddr_c = tx_load_c ? ptr_q : host_addr;

  i2c_reg_bank #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bank (
    .clk        (clk),
    .rst        (rst),
    .i2c_we     (i2c_we_c),
    .i2c_waddr  (ptr_q),
    .i2c_wdata  (slv_data_out),
    .host_we    (host_wr_c),
    .host_waddr (host_addr),
    .host_wdata (host_wdata),
    .raddr      (raddr_c),
    .rdata_c    (rdata_c)
  );

  // Transaction FSM: disable > stop > (repeated) start > byte events
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    i2c_we_c   = 1'b0;
    tx_load_c  = 1'b0;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    if (!cfg_enable) begin
      state_d = ST_IDLE;
    end else if (sto_c) begin
      state_d = ST_IDLE;
    end else if (sta_c) begin
      state_d = ST_PTR;
    end else begin
      case (state_q)
        ST_PTR: begin
          if (rx_evt_c) begin
            ptr_d   = slv_data_out[AW-1:0];
            state_d = ST_WR;
          end else if (tx_evt_c) begin
            tx_load_c = 1'b1;
            state_d   = ST_RD;
          end
        end
        ST_WR: begin
          if (rx_evt_c) begin
            i2c_we_c   = 1'b1;
            wr_pulse_d = 1'b1;
            wr_addr_d  = ptr_q;
            ptr_d      = ptr_q + AW'(1);
          end else if (tx_evt_c) begin
            state_d = ST_RD;
          end
        end
        ST_RD: begin
          if (tx_evt_c && !rx_evt_c) tx_load_c = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (tx_load_c) ptr_d = ptr_q + AW'(1);
  end

  // Tx data path, enable delay line and host completion
  always_comb begin
    data_in_d    = tx_load_c ? rdata_c : data_in_q;
    sh_d         = '0;
    sh_d[0]      = tx_load_c;
    for (int i = 1; i < int'(SHW); i++) sh_d[i] = sh_q[i-1];
    tx_en_d      = sh_q[SHW-1] & cfg_enable;
    if (!cfg_enable) sh_d = '0;
    host_ack_d   = host_serve_c;
    host_rdata_d = (host_serve_c && !host_we) ? rdata_c : host_rdata_q;
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q       <= MODE_OFF;
      dev_q        <= 7'h00;
      tmo_q        <= 20'h0_0000;
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      rx_lvl_q     <= 1'b0;
      tx_lvl_q     <= 1'b0;
      data_in_q    <= 8'h00;
      sh_q         <= '0;
      tx_en_q      <= 1'b0;
      host_rdata_q <= 8'h00;
      host_ack_q   <= 1'b0;
      wr_pulse_q   <= 1'b0;
      wr_addr_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      mode_q       <= cfg_enable ? MODE_SLAVE : MODE_OFF;
      dev_q        <= cfg_dev_addr;
      tmo_q        <= cfg_time_out;
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rx_lvl_q     <= slv_status[RX_ACK];
      tx_lvl_q     <= slv_status[TX_ACK];
      data_in_q    <= data_in_d;
      sh_q         <= sh_d;
      tx_en_q      <= tx_en_d;
      host_rdata_q <= host_rdata_d;
      host_ack_q   <= host_ack_d;
      wr_pulse_q   <= wr_pulse_d;
      wr_addr_q    <= wr_addr_d;
      busy_q       <= busy_d;
    end
  end

  assign slv_mode_i2c    = mode_q;
  assign slv_addr_device = dev_q;
  assign slv_time_out    = tmo_q;
  assign slv_data_in     = data_in_q;
  assign slv_tx_data_en  = tx_en_q;
  assign host_rdata      = host_rdata_q;
  assign host_ack        = host_ack_q;
  assign i2c_wr_pulse    = wr_pulse_q;
  assign i2c_wr_addr     = wr_addr_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_i2c_slave_reg_ctrl.sv
// Self-checking bench for i2c_slave_reg_ctrl: host-port vector table,
// directed I2C sequences and randomized traffic against a register model.
module tb_i2c_slave_reg_ctrl;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_enable;
  logic [6:0]    cfg_dev_addr;
  logic [19:0]   cfg_time_out;
  logic [7:0]    slv_status;
  logic [7:0]    slv_data_out;
  logic [1:0]    slv_mode_i2c;
  logic [6:0]    slv_addr_device;
  logic [19:0]   slv_time_out;
  logic [7:0]    slv_data_in;
  logic          slv_tx_data_en;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata;
  logic [7:0]    host_rdata;
  logic          host_ack;
  logic          i2c_wr_pulse;
  logic [AW-1:0] i2c_wr_addr;
  logic          busy;

  always #5 clk = ~clk;

  i2c_slave_reg_ctrl #(.DEPTH(DEPTH), .AW(AW), .TX_LAT(2)) dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_dev_addr(cfg_dev_addr),
    .cfg_time_out(cfg_time_out), .slv_status(slv_status), .slv_data_out(slv_data_out),
    .slv_mode_i2c(slv_mode_i2c), .slv_addr_device(slv_addr_device),
    .slv_time_out(slv_time_out), .slv_data_in(slv_data_in),
    .slv_tx_data_en(slv_tx_data_en), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .host_ack(host_ack), .i2c_wr_pulse(i2c_wr_pulse), .i2c_wr_addr(i2c_wr_addr),
    .busy(busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: register contents and the pointer
  logic [7:0] mdl_mem [DEPTH];
  int         mdl_ptr;

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } hvec_t;
  hvec_t vec [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mdl_reset;
    for (int i = 0; i < int'(DEPTH); i++) mdl_mem[i] = 8'h00;
    mdl_ptr = 0;
  endtask

  task automatic i2c_sta;
    slv_status = 8'h01;
    tick;
    slv_status = 8'h00;
  endtask

  task automatic i2c_sto;
    slv_status = 8'h02;
    tick;
    slv_status = 8'h00;
  endtask

  // One received byte; the first byte after a start is the register pointer
  task automatic do_rx(input logic [7:0] b, input bit is_ptr);
    int a;
    slv_data_out = b;
    slv_status   = 8'h08;
    tick;
    if (is_ptr) begin
      mdl_ptr = b % DEPTH;
      chk("rx_ptr_no_pulse", i2c_wr_pulse, 0);
    end else begin
      a = mdl_ptr;
      mdl_mem[a] = b;
      mdl_ptr = (mdl_ptr + 1) % DEPTH;
      chk("rx_wr_pulse", i2c_wr_pulse, 1);
      chk("rx_wr_addr", i2c_wr_addr, a);
    end
    slv_status = 8'h00;
    tick;
    chk("rx_pulse_end", i2c_wr_pulse, 0);
  endtask

  // One transmit request; enable must appear exactly two cycles later
  task automatic do_tx;
    logic [7:0] e;
    e = mdl_mem[mdl_ptr];
    mdl_ptr = (mdl_ptr + 1) % DEPTH;
    slv_status = 8'h04;
    tick;
    chk("tx_data", slv_data_in, e);
    chk("tx_en_early", slv_tx_data_en, 0);
    slv_status = 8'h00;
    tick;
    chk("tx_en_pulse", slv_tx_data_en, 1);
    chk("tx_data_hold", slv_data_in, e);
    tick;
    chk("tx_en_end", slv_tx_data_en, 0);
  endtask

  task automatic host_xfer(input logic we, input logic [3:0] a, input logic [7:0] d,
                           output logic [7:0] rd);
    bit seen;
    seen = 0;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    for (int k = 0; k < 10; k++) begin
      tick;
      if (host_ack) begin
        seen = 1;
        break;
      end
    end
    chk("host_ack_seen", seen, 1);
    rd = host_rdata;
    host_req = 1'b0;
    if (we) mdl_mem[a] = d;
  endtask

  task automatic host_rd_chk(input logic [3:0] a);
    logic [7:0] rd;
    host_xfer(1'b0, a, 8'h00, rd);
    chk("host_rd_model", rd, mdl_mem[a]);
  endtask

  task automatic host_wr(input logic [3:0] a, input logic [7:0] d);
    logic [7:0] rd;
    host_xfer(1'b1, a, d, rd);
  endtask

  initial begin
    logic [7:0] rd;
    int acks, n, op;

    vec[0] = '{1'b1, 4'd0,  8'h12, 8'h00};
    vec[1] = '{1'b1, 4'd5,  8'hA5, 8'h00};
    vec[2] = '{1'b1, 4'd15, 8'hF0, 8'h00};
    vec[3] = '{1'b0, 4'd0,  8'h00, 8'h12};
    vec[4] = '{1'b0, 4'd5,  8'h00, 8'hA5};
    vec[5] = '{1'b0, 4'd15, 8'h00, 8'hF0};
    vec[6] = '{1'b0, 4'd1,  8'h00, 8'h00};
    vec[7] = '{1'b0, 4'd9,  8'h00, 8'h00};

    rst = 1'b0; cfg_enable = 1'b0; cfg_dev_addr = 7'h00; cfg_time_out = 20'h0;
    slv_status = 8'h00; slv_data_out = 8'h00;
    host_req = 1'b0; host_we = 1'b0; host_addr = 4'h0; host_wdata = 8'h00;
    mdl_reset();
    tick; tick;
    chk("rst_mode", slv_mode_i2c, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_en", slv_tx_data_en, 0);
    chk("rst_host_ack", host_ack, 0);
    rst = 1'b1;
    cfg_enable = 1'b1; cfg_dev_addr = 7'h2A; cfg_time_out = 20'hABCDE;
    tick;
    chk("cfg_mode", slv_mode_i2c, 2'b01);
    chk("cfg_addr", slv_addr_device, 7'h2A);
    chk("cfg_tmo", slv_time_out, 20'hABCDE);

    // Host vector table
    for (int i = 0; i < 8; i++) begin
      host_xfer(vec[i].we, vec[i].addr, vec[i].wdata, rd);
      if (!vec[i].we) chk("vec_rdata", rd, vec[i].exp);
    end

    // Continuous host request: at most one ack every two cycles
    acks = 0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 4'd5;
    for (int k = 0; k < 6; k++) begin
      tick;
      if (host_ack) acks++;
    end
    host_req = 1'b0;
    tick;
    chk("host_ack_rate", acks, 3);

    // Write burst then confirm pointer ended at 5
    host_wr(4'd5, 8'h3C);
    i2c_sta();
    chk("busy_after_sta", busy, 1);
    do_rx(8'h03, 1);
    do_rx(8'hAA, 0);
    do_rx(8'h55, 0);
    i2c_sto();
    chk("busy_after_sto", busy, 0);
    host_rd_chk(4'd3);
    host_rd_chk(4'd4);
    i2c_sta(); do_tx(); i2c_sto();

    // Combined write-pointer / repeated-start read
    host_wr(4'd7, 8'h5C);
    host_wr(4'd8, 8'hC3);
    i2c_sta(); do_rx(8'h07, 1); i2c_sta(); do_tx(); do_tx(); i2c_sto();

    // Pointer wrap and ignored upper pointer bits
    i2c_sta(); do_rx(8'h0F, 1); do_rx(8'h11, 0); do_rx(8'h22, 0); do_rx(8'h33, 0); i2c_sto();
    host_rd_chk(4'd15); host_rd_chk(4'd0); host_rd_chk(4'd1);
    i2c_sta(); do_rx(8'h1F, 1); i2c_sta(); do_tx(); i2c_sto();

    // Host write colliding with an I2C write to the same register
    i2c_sta(); do_rx(8'h02, 1);
    slv_data_out = 8'h44; slv_status = 8'h08;
    host_req = 1'b1; host_we = 1'b1; host_addr = 4'd2; host_wdata = 8'h99;
    tick;
    chk("coll_i2c_pulse", i2c_wr_pulse, 1);
    chk("coll_host_wait", host_ack, 0);
    slv_status = 8'h00;
    tick;
    chk("coll_host_ack", host_ack, 1);
    host_req = 1'b0;
    mdl_mem[2] = 8'h99; mdl_ptr = 3;
    tick;
    i2c_sto();
    host_rd_chk(4'd2);

    // Disable one cycle after a tx event: load aborted, no enable pulse
    i2c_sta(); do_rx(8'h07, 1); i2c_sta();
    slv_status = 8'h04;
    tick;
    mdl_ptr = (mdl_ptr + 1) % DEPTH;
    cfg_enable = 1'b0; slv_status = 8'h00;
    tick;
    chk("dis_no_en", slv_tx_data_en, 0);
    chk("dis_mode", slv_mode_i2c, 0);
    chk("dis_idle", busy, 0);
    tick;
    chk("dis_no_en_late", slv_tx_data_en, 0);
    cfg_enable = 1'b1;
    tick;

    // Randomized traffic against the model
    for (int r = 0; r < 40; r++) begin
      op = int'($urandom_range(0, 3));
      case (op)
        0: host_wr(4'($urandom_range(0, 15)), 8'($urandom));
        1: host_rd_chk(4'($urandom_range(0, 15)));
        2: begin
          i2c_sta(); do_rx(8'($urandom), 1);
          n = int'($urandom_range(1, 3));
          for (int j = 0; j < n; j++) do_rx(8'($urandom), 0);
          i2c_sto();
        end
        default: begin
          i2c_sta(); do_rx(8'($urandom), 1); i2c_sta();
          n = int'($urandom_range(1, 3));
          for (int j = 0; j < n; j++) do_tx();
          i2c_sto();
        end
      endcase
    end

    // Async reset in the middle of a read: outputs clear immediately
    host_wr(4'd6, 8'h6B);
    host_rd_chk(4'd6);
    i2c_sta(); do_rx(8'h05, 1); do_rx(8'h77, 0); i2c_sta();
    slv_status = 8'h04;
    tick;
    slv_status = 8'h00;
    #1 rst = 1'b0;
    #1;
    chk("amid_data_in", slv_data_in, 0);
    chk("amid_tx_en", slv_tx_data_en, 0);
    chk("amid_busy", busy, 0);
    chk("amid_mode", slv_mode_i2c, 0);
    chk("amid_dev", slv_addr_device, 0);
    chk("amid_tmo", slv_time_out, 0);
    chk("amid_rdata", host_rdata, 0);
    tick;
    chk("amid_no_en", slv_tx_data_en, 0);
    rst = 1'b1;
    mdl_reset();
    tick;
    chk("amid_no_en2", slv_tx_data_en, 0);
    chk("post_rst_mode", slv_mode_i2c, 2'b01);
    host_rd_chk(4'd6);
    host_rd_chk(4'd5);
    i2c_sta(); do_tx(); i2c_sto();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
